// File: rtl/cov_accum.sv
// Streaming 2x2 covariance accumulator: sums outer products of N = 2^LOG2_N samples.
// Optional COV_SCALE_EN divides each sum by N (arithmetic shift); otherwise raw sums are output.
module cov_accum #(
  parameter int unsigned DW     = 32,
  parameter int unsigned LOG2_N = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] x0,
  input  logic signed [DW-1:0] x1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [63:0]          A0,
  output logic [63:0]          A1,
  output logic [63:0]          A2,
  output logic [63:0]          A3
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned AW = PW + LOG2_N;
  localparam int unsigned WW = (AW > 64) ? AW : 64;
  localparam int unsigned CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << LOG2_N) - 1);

  typedef enum logic [1:0] {ST_ACCUM, ST_DRAIN, ST_HOLD} state_e;

  state_e                state_q, state_d;
  logic                  drain_q, drain_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic signed [PW-1:0]  p00_q, p00_d, p01_q, p01_d, p11_q, p11_d;
  logic                  pv_q, pv_d, plast_q, plast_d;
  logic signed [AW-1:0]  acc00_q, acc00_d, acc01_q, acc01_d, acc11_q, acc11_d;
  logic signed [AW-1:0]  sum00, sum01, sum11;
  logic [63:0]           a0_q, a0_d, a1_q, a1_d, a3_q, a3_d;
  logic                  xfer_c, last_c;

  assign xfer_c = in_valid & in_ready_q;
  assign last_c = xfer_c && (cnt_q == LAST_CNT);

  // Widen the final sum, optionally divide by N with floor rounding, keep low 64 bits.
  function automatic logic [63:0] to_word(input logic signed [AW-1:0] s);
    logic signed [WW-1:0] w;
    w = WW'(s);
`ifdef COV_SCALE_EN
    w = w >>> LOG2_N;
`endif
    return 64'(w);
  endfunction

  // Block control: count N transfers, flush the two-stage pipe, hold the result.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (xfer_c) begin
          if (last_c) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
            drain_d = 1'b0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q) begin
          state_d = ST_HOLD;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) state_d = ST_ACCUM;
      end
      default: state_d = ST_ACCUM;
    endcase
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_HOLD);
  end

  // Stage 1 products and stage 2 accumulation / result load.
  always_comb begin
    p00_d   = xfer_c ? PW'(x0) * PW'(x0) : p00_q;
    p01_d   = xfer_c ? PW'(x0) * PW'(x1) : p01_q;
    p11_d   = xfer_c ? PW'(x1) * PW'(x1) : p11_q;
    pv_d    = xfer_c;
    plast_d = last_c;

    sum00   = acc00_q + AW'(p00_q);
    sum01   = acc01_q + AW'(p01_q);
    sum11   = acc11_q + AW'(p11_q);

    acc00_d = acc00_q;
    acc01_d = acc01_q;
    acc11_d = acc11_q;
    a0_d    = a0_q;
    a1_d    = a1_q;
    a3_d    = a3_q;
    if (pv_q) begin
      if (plast_q) begin
        acc00_d = '0;
        acc01_d = '0;
        acc11_d = '0;
        a0_d    = to_word(sum00);
        a1_d    = to_word(sum01);
        a3_d    = to_word(sum11);
      end else begin
        acc00_d = sum00;
        acc01_d = sum01;
        acc11_d = sum11;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_ACCUM;
      drain_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      p00_q       <= '0;
      p01_q       <= '0;
      p11_q       <= '0;
      pv_q        <= 1'b0;
      plast_q     <= 1'b0;
      acc00_q     <= '0;
      acc01_q     <= '0;
      acc11_q     <= '0;
      a0_q        <= '0;
      a1_q        <= '0;
      a3_q        <= '0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      p00_q       <= p00_d;
      p01_q       <= p01_d;
      p11_q       <= p11_d;
      pv_q        <= pv_d;
      plast_q     <= plast_d;
      acc00_q     <= acc00_d;
      acc01_q     <= acc01_d;
      acc11_q     <= acc11_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      a3_q        <= a3_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign A0        = a0_q;
  assign A1        = a1_q;
  assign A2        = a1_q;
  assign A3        = a3_q;

endmodule

// File: tb/tb_cov_accum.sv
// Bench for cov_accum with N=4, DW=32; expected values follow COV_SCALE_EN when defined.
module tb_cov_accum;

  localparam int unsigned DW     = 32;
  localparam int unsigned LOG2_N = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] x0, x1;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   A0, A1, A2, A3;

  int errors = 0;
  int checks = 0;

  cov_accum #(.DW(DW), .LOG2_N(LOG2_N)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x0), .x1(x1), .out_valid(out_valid), .out_ready(out_ready),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [63:0]      e0;
    logic [63:0]      e1;
    logic [63:0]      e3;
  } vec_t;

  vec_t tbl [3];

  // Expected output word for an exact block sum.
  function automatic logic [63:0] exp_of(input longint s);
`ifdef COV_SCALE_EN
    return 64'(s >>> LOG2_N);
`else
    return 64'(s);
`endif
  endfunction

  function automatic vec_t mk(input int a0, a1, a2, a3, b0, b1, b2, b3,
                              input longint s00, s01, s11);
    vec_t v;
    v.a  = {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
    v.b  = {32'(b3), 32'(b2), 32'(b1), 32'(b0)};
    v.e0 = exp_of(s00);
    v.e1 = exp_of(s01);
    v.e3 = exp_of(s11);
    return v;
  endfunction

  // Reference: exact sum of products in wide arithmetic, then the output rule.
  function automatic logic [63:0] ref_word(input logic [3:0][31:0] a, input logic [3:0][31:0] b);
    logic signed [127:0] s;
    s = '0;
    for (int i = 0; i < 4; i++)
      s = s + 128'($signed(a[i])) * 128'($signed(b[i]));
`ifdef COV_SCALE_EN
    s = s >>> LOG2_N;
`endif
    return s[63:0];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", nm, $signed(act), $signed(exp));
    end
  endtask

  task automatic send_sample(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    @(negedge clk);
    x0 = a;
    x1 = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic receive(input string nm, input logic [63:0] e0, e1, e3, input int delay);
    int n;
    n = 0;
    out_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({nm, "_timeout_out_valid"}, 64'(out_valid), 64'd1);
      return;
    end
    chk({nm, "_A0"}, A0, e0);
    chk({nm, "_A1"}, A1, e1);
    chk({nm, "_A2"}, A2, e1);
    chk({nm, "_A3"}, A3, e3);
    repeat (delay) begin
      @(negedge clk);
      chk({nm, "_hold_A0"}, A0, e0);
      chk({nm, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_after_out_valid"}, 64'(out_valid), 64'd0);
    chk({nm, "_after_A3"}, A3, e3);
  endtask

  initial begin
    logic [3:0][31:0] ra, rb;
    int n;
    bit seen;

    reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    x0 = '0;
    x1 = '0;
    tbl[0] = mk(-3, 3, -3, 3, 5, -5, 5, -5, 36, -60, 100);
    tbl[1] = mk(1, 0, 0, 0, -1, 0, 0, 0, 1, -1, 1);
    tbl[2] = mk(2, 4, -6, 0, -1, 3, 2, 5, 56, -2, 39);
    tbl[1].e3 = exp_of(1);
    tbl[1].e0 = exp_of(1);
    tbl[1].e3 = exp_of(1);

    repeat (2) @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_A0", A0, 64'd0);
    chk("reset_A3", A3, 64'd0);
    reset = 1'b1;

    // Basic block with exact latency and one-cycle HOLD.
    out_ready = 1'b1;
    repeat (4) send_sample(32'd1, 32'd2);
    @(negedge clk); chk("basic_lat1_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("basic_lat2_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk); chk("basic_lat3_out_valid", 64'(out_valid), 64'd1);
    chk("basic_in_ready_hold", 64'(in_ready), 64'd0);
    chk("basic_A0", A0, exp_of(4));
    chk("basic_A1", A1, exp_of(8));
    chk("basic_A2", A2, exp_of(8));
    chk("basic_A3", A3, exp_of(16));
    @(negedge clk); chk("basic_end_out_valid", 64'(out_valid), 64'd0);
    chk("basic_end_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b0;

    // Table-driven blocks.
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) send_sample(tbl[t].a[i], tbl[t].b[i]);
      receive($sformatf("tbl%0d", t), tbl[t].e0, tbl[t].e1, tbl[t].e3, 0);
    end

    // Backpressure with in_valid held high while HOLD.
    repeat (4) send_sample(32'd1, 32'd2);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    x0 = 32'd7;
    x1 = 32'd7;
    in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("bp_A0", A0, exp_of(4));
      chk("bp_A1", A1, exp_of(8));
      chk("bp_A3", A3, exp_of(16));
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid_hold", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    chk("bp_keep_A1", A1, exp_of(8));
    repeat (4) send_sample(32'd3, 32'd1);
    receive("bp_next", exp_of(36), exp_of(12), exp_of(4), 0);

    // Bubbles between transfers still yield exactly one result.
    for (int i = 0; i < 4; i++) begin
      send_sample(32'd2, 32'd3);
      @(negedge clk);
    end
    receive("bubble", exp_of(16), exp_of(24), exp_of(36), 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("bubble_single_result", 64'(seen), 64'd0);

    // Reset mid-block discards the partial block.
    repeat (2) send_sample(32'd9, 32'd9);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_A0", A0, 64'd0);
    chk("midrst_A1", A1, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) send_sample(32'd1, 32'd1);
    receive("after_rst", exp_of(4), exp_of(4), exp_of(4), 0);

    // Random blocks against the reference model.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 4; i++) begin
        ra[i] = $urandom;
        rb[i] = $urandom;
        send_sample(ra[i], rb[i]);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      receive($sformatf("rand%0d", blk), ref_word(ra, ra), ref_word(ra, rb),
              ref_word(rb, rb), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cov_accum.md
# cov_accum

Streaming covariance accumulator that sits directly upstream of the QR Gram-Schmidt stage in the PCA precoder. It accepts 2-element signed sample vectors, accumulates the outer products over a block of N = 2^LOG2_N samples, and presents the 2x2 covariance matrix as four 64-bit words A0..A3. Each result is held under a valid/ready handshake until the QR stage takes it.

## Interface
- DW, 32: signed sample width (DW <= 32).
- LOG2_N, 4: log2 of block length N, range 1..8.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present on x0/x1.
- in_ready  out  1  block accepts a sample this cycle.
- x0  in  DW  sample element 0, signed.
- x1  in  DW  sample element 1, signed.
- out_valid  out  1  A0..A3 hold a completed matrix.
- out_ready  in  1  downstream consumes the matrix.
- A0  out  64  a11 = Σx0·x0, row-major, scaled.
- A1  out  64  a12 = Σx0·x1.
- A2  out  64  a21 = Σx1·x0, always equal to A1.
- A3  out  64  a22 = Σx1·x1.

## Operation
- Column 0 of the matrix is (A0, A2) and column 1 is (A1, A3), matching the QR stage input order.
- FSM has three states:
  - ACCUM: in_ready=1. Each in_valid&in_ready edge is a transfer. After the Nth transfer the FSM moves to DRAIN.
  - DRAIN: in_ready=0, lasts exactly 2 cycles while the pipeline flushes. At the end of the 2nd cycle it moves to HOLD.
  - HOLD: out_valid=1, in_ready=0. On out_valid&out_ready it moves to ACCUM.
- Pipeline stage 1 registers the signed products p00=x0·x0, p01=x0·x1, p11=x1·x1 (2·DW bits each) plus a valid bit and a last bit.
- Stage 2 has three signed accumulators of width 2·DW+LOG2_N.
  - A valid product is added to its accumulator.
  - On the last product, acc+product is written to the output registers and all accumulators clear in the same edge.
- Output word = low 64 bits of (final sum >>> LOG2_N): arithmetic shift, floor rounding, sign-extended to 64.
- Sample counter is LOG2_N+1 bits. It clears on entry to DRAIN.
- in_valid while in_ready=0 is ignored: no count, no accumulate.
- in_valid may drop between samples. Bubbles add nothing.
- Reset asserted at any point, including mid-block or during HOLD:
  - state goes to ACCUM.
  - counter, accumulators, pipeline valid bits and A0..A3 all clear to 0.
  - out_valid=0.
  - A partial block is discarded.

## Timing
- Reset values: in_ready=1, out_valid=0, A0..A3=0.
- Nth sample accepted at edge k: product registered at k, outputs loaded at k+1, out_valid high after edge k+2.
- A0..A3 stay stable from out_valid rise until the handshake edge. They keep their value after the handshake until the next load.
- out_valid falls and in_ready rises on the edge after out_valid&out_ready.
- If out_ready is already high when out_valid rises, HOLD lasts 1 cycle.
- Minimum block period: N+3 cycles (N transfers + 2 DRAIN + 1 HOLD).
- out_ready while out_valid=0 has no effect.

## Configuration
- COV_SCALE_EN defined: outputs are divided by N (>>> LOG2_N) as above.
- COV_SCALE_EN undefined: outputs are the raw sums, truncated to their low 64 bits; no shift.
- Latency, handshake and FSM are identical in both builds.

## Test plan
All scenarios use LOG2_N=2 (N=4), DW=32 and COV_SCALE_EN defined unless stated.
- Basic block: (1,2) sent 4 times back-to-back, out_ready=1 → A0=1, A1=A2=2, A3=4. out_valid rises 2 edges after the 4th transfer and is high 1 cycle.
- Signed values: (-3,5),(3,-5),(-3,5),(3,-5) → A0=9, A1=A2=-15, A3=25.
- Floor rounding: (1,-1),(0,0),(0,0),(0,0) → A0=0, A1=A2=-1, A3=0.
- Backpressure: out_ready held low 10 cycles after out_valid, in_valid held high with (7,7):
  - A0..A3 stay stable.
  - in_ready=0 throughout.
  - the next block sums only the samples sent after the handshake.
- Bubbles and reset:
  - in_valid pattern 1,0,1,0,… still produces one result after exactly 4 transfers.
  - reset pulsed after 2 transfers of (9,9), then 4 samples of (1,1) → A0..A3 all = 1.
- Raw sums (COV_SCALE_EN undefined): (1,2) sent 4 times → A0=4, A1=A2=8, A3=16.
